// File: rtl/mode_3_sprite_fetch_if.sv
// Signal bundle between the mode 3 sprite fetcher, OAM queue, VRAM and pixel mixer.
interface mode_3_sprite_fetch_if #(
    parameter int SPRITE_COUNT = 10
);
    logic                          start;
    logic [SPRITE_COUNT-1:0][47:0] sprite_queue_in;
    logic [7:0]                    LCDC;
    logic [7:0]                    LY;
    logic [7:0]                    lx;
    logic                          check;
    logic [7:0]                    vram_dout;
    logic [15:0]                   vram_a;
    logic                          busy;
    logic                          result_valid;
    logic                          hit;
    logic [7:0]                    pix_lo;
    logic [7:0]                    pix_hi;
    logic [7:0]                    flags_out;
    logic [3:0]                    sprite_idx;

    modport master (
        output start, sprite_queue_in, LCDC, LY, lx, check, vram_dout,
        input  vram_a, busy, result_valid, hit, pix_lo, pix_hi,
        input  flags_out, sprite_idx
    );

    modport slave (
        input  start, sprite_queue_in, LCDC, LY, lx, check, vram_dout,
        output vram_a, busy, result_valid, hit, pix_lo, pix_hi,
        output flags_out, sprite_idx
    );
endinterface

// File: rtl/mode_3_sprite_fetch.sv
// Mode 3 sprite fetcher: match queued sprite at lx, fetch its tile row from VRAM.
// Define SPRITE_TALL_EN to let LCDC[2] select 8x16 sprites.
module mode_3_sprite_fetch #(
    parameter int          SPRITE_COUNT = 10,
    parameter logic [15:0] VRAM_BASE    = 16'h8000
) (
    input  logic                  clk,
    input  logic                  rst,
    mode_3_sprite_fetch_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_WAIT_LO, S_WAIT_HI, S_OUT
    } state_t;

    state_t r_state, w_next;

    logic [SPRITE_COUNT-1:0]      r_valid, r_used;
    logic [SPRITE_COUNT-1:0][7:0] r_y, r_x, r_tile, r_flags;
    logic [7:0]  r_ly, r_lx, r_lo, r_sel_flags;
    logic        r_tall, r_cnt;
    logic [3:0]  r_sel;
    logic [15:0] r_vram_a;
    logic        r_hit;
    logic [7:0]  r_pix_lo, r_pix_hi, r_flags_out;
    logic [3:0]  r_sprite_idx;

    logic        w_found, w_tall, w_unused;
    logic [3:0]  w_idx, w_row;
    logic [7:0]  w_diff, w_tile;
    logic [15:0] w_addr_lo;

`ifdef SPRITE_TALL_EN
    assign w_tall = r_tall;
`else
    logic w_unused_tall;
    assign w_tall        = 1'b0;
    assign w_unused_tall = r_tall;
`endif

    function automatic logic [7:0] f_rev(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    // OAM address low byte and unused LCDC bits carry no meaning here
    always_comb begin
        w_unused = ^{bus.LCDC[7:3], bus.LCDC[1:0]};
        for (int i = 0; i < SPRITE_COUNT; i++)
            w_unused = w_unused ^ (^bus.sprite_queue_in[i][39:32]);
    end

    // Lowest-index unused valid entry at the requested X
    always_comb begin
        w_found = 1'b0;
        w_idx   = 4'd0;
        for (int i = 0; i < SPRITE_COUNT; i++) begin
            if (!w_found && r_valid[i] && !r_used[i] && r_x[i] == r_lx) begin
                w_found = 1'b1;
                w_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        w_diff = r_ly + 8'd16 - r_y[w_idx];
        if (w_tall) begin
            w_row  = w_diff[3:0];
            w_tile = {r_tile[w_idx][7:1], 1'b0};
        end else begin
            w_row  = {1'b0, w_diff[2:0]};
            w_tile = r_tile[w_idx];
        end
        if (r_flags[w_idx][6])
            w_row = (w_tall ? 4'd15 : 4'd7) - w_row;
        w_addr_lo = VRAM_BASE + {4'b0000, w_tile, 4'b0000}
                  + {11'd0, w_row, 1'b0};
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (bus.check) w_next = S_SCAN;
            S_SCAN:    w_next = w_found ? S_WAIT_LO : S_OUT;
            S_WAIT_LO: if (r_cnt) w_next = S_WAIT_HI;
            S_WAIT_HI: if (r_cnt) w_next = S_OUT;
            S_OUT:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (bus.start) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= '0;
            r_used       <= '0;
            r_y          <= '0;
            r_x          <= '0;
            r_tile       <= '0;
            r_flags      <= '0;
            r_ly         <= '0;
            r_tall       <= 1'b0;
            r_lx         <= '0;
            r_cnt        <= 1'b0;
            r_sel        <= '0;
            r_sel_flags  <= '0;
            r_lo         <= '0;
            r_vram_a     <= '0;
            r_hit        <= 1'b0;
            r_pix_lo     <= '0;
            r_pix_hi     <= '0;
            r_flags_out  <= '0;
            r_sprite_idx <= '0;
        end else if (bus.start) begin
            for (int i = 0; i < SPRITE_COUNT; i++) begin
                r_valid[i] <= bus.sprite_queue_in[i][47:40] == 8'hFE;
                r_y[i]     <= bus.sprite_queue_in[i][31:24];
                r_x[i]     <= bus.sprite_queue_in[i][23:16];
                r_tile[i]  <= bus.sprite_queue_in[i][15:8];
                r_flags[i] <= bus.sprite_queue_in[i][7:0];
            end
            r_ly   <= bus.LY;
            r_tall <= bus.LCDC[2];
            r_used <= '0;
            r_cnt  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: r_lx <= bus.lx;
                S_SCAN: begin
                    r_cnt <= 1'b0;
                    if (w_found) begin
                        r_vram_a       <= w_addr_lo;
                        r_used[w_idx]  <= 1'b1;
                        r_sel          <= w_idx;
                        r_sel_flags    <= r_flags[w_idx];
                    end else begin
                        r_hit <= 1'b0;
                    end
                end
                S_WAIT_LO: begin
                    r_cnt <= ~r_cnt;
                    if (r_cnt) begin
                        r_lo     <= bus.vram_dout;
                        r_vram_a <= r_vram_a + 16'd1;
                    end
                end
                S_WAIT_HI: begin
                    r_cnt <= ~r_cnt;
                    if (r_cnt) begin
                        r_pix_lo     <= r_sel_flags[5] ? f_rev(r_lo) : r_lo;
                        r_pix_hi     <= r_sel_flags[5] ? f_rev(bus.vram_dout)
                                                       : bus.vram_dout;
                        r_flags_out  <= r_sel_flags;
                        r_sprite_idx <= r_sel;
                        r_hit        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.vram_a       = r_vram_a;
    assign bus.busy         = r_state != S_IDLE;
    assign bus.result_valid = r_state == S_OUT;
    assign bus.hit          = r_hit;
    assign bus.pix_lo       = r_pix_lo;
    assign bus.pix_hi       = r_pix_hi;
    assign bus.flags_out    = r_flags_out;
    assign bus.sprite_idx   = r_sprite_idx;
endmodule

// File: tb/tb_mode_3_sprite_fetch.sv
// Randomised and directed bench for mode_3_sprite_fetch with a queue-level model.
module tb_mode_3_sprite_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mode_3_sprite_fetch_if bus ();
    mode_3_sprite_fetch dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [65536];
    always @(posedge clk) bus.vram_dout <= mem[bus.vram_a];

    typedef struct packed {
        logic        hit;
        logic [3:0]  idx;
        logic [15:0] alo;
        logic [15:0] ahi;
        logic [7:0]  plo;
        logic [7:0]  phi;
        logic [7:0]  fl;
    } res_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [47:0] mq [10];
    bit          mused [10];
    logic [7:0]  mly;
    bit          mtall;
    logic [15:0] mva;

    function automatic logic [47:0] ent(input logic [7:0] y, x, t, f);
        return {16'hFE00, y, x, t, f};
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 10; i++) mq[i] = '0;
    endtask

    task automatic m_predict(input logic [7:0] lx, output res_t e);
        int idx, row, ht;
        logic [7:0] y, tl, fl, b;
        e = '0;
        idx = -1;
        for (int i = 0; i < 10; i++)
            if (idx < 0 && mq[i][47:40] == 8'hFE && !mused[i] && mq[i][23:16] == lx)
                idx = i;
        if (idx < 0) begin
            e.alo = mva;
        end else begin
            y  = mq[idx][31:24];
            tl = mq[idx][15:8];
            fl = mq[idx][7:0];
            ht = mtall ? 16 : 8;
            row = (((int'(mly) + 16 - int'(y)) % 256 + 256) % 256) % ht;
            if (fl[6]) row = ht - 1 - row;
            if (ht == 16) tl[0] = 1'b0;
            e.alo = 16'(32'h8000 + int'(tl) * 16 + row * 2);
            e.ahi = e.alo + 16'd1;
            b = mem[e.alo];
            if (fl[5]) e.plo = {<<{b}}; else e.plo = b;
            b = mem[e.ahi];
            if (fl[5]) e.phi = {<<{b}}; else e.phi = b;
            e.hit = 1'b1;
            e.idx = 4'(idx);
            e.fl  = fl;
            mused[idx] = 1'b1;
            mva = e.ahi;
        end
    endtask

    task automatic do_start(input logic [7:0] ly, input logic [7:0] lcdc);
        @(negedge clk);
        for (int i = 0; i < 10; i++) bus.sprite_queue_in[i] = mq[i];
        bus.LY = ly;
        bus.LCDC = lcdc;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) mused[i] = 1'b0;
        mly = ly;
`ifdef SPRITE_TALL_EN
        mtall = lcdc[2];
`else
        mtall = 1'b0;
`endif
    endtask

    task automatic do_check(input logic [7:0] lx, output res_t g,
                            output int lat, output logic b0);
        g = '0;
        lat = 0;
        @(negedge clk);
        bus.lx = lx;
        bus.check = 1'b1;
        @(negedge clk);
        bus.check = 1'b0;
        b0 = bus.busy;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) g.alo = bus.vram_a;
            if (n == 3) g.ahi = bus.vram_a;
            if (bus.result_valid) begin
                lat   = n;
                g.hit = bus.hit;
                g.idx = bus.sprite_idx;
                g.plo = bus.pix_lo;
                g.phi = bus.pix_hi;
                g.fl  = bus.flags_out;
            end
        end
    endtask

    task automatic test_reset();
        logic [46:0] o;
        rst = 1'b1;
        #12;
        o = {bus.vram_a, bus.busy, bus.result_valid, bus.hit, bus.pix_lo,
             bus.pix_hi, bus.flags_out, bus.sprite_idx};
        n_chk++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) mused[i] = 1'b0;
        mva = '0;
    endtask

    task automatic test_single_hit();
        res_t g, e;
        int lat;
        logic b0;
        m_clear();
        mq[0] = ent(8'd16, 8'd20, 8'h12, 8'h00);
        do_start(8'd5, 8'h00);
        m_predict(8'd20, e);
        do_check(8'd20, g, lat, b0);
        n_chk++;
        if (b0 !== 1'b1) begin n_fail++; $display("FAIL hit_busy: got %b want 1", b0); end
        n_chk++;
        if (lat != 5) begin n_fail++; $display("FAIL hit_latency: got %0d want 5", lat); end
        n_chk++;
        if (g.alo !== 16'h812A || g.ahi !== 16'h812B) begin
            n_fail++;
            $display("FAIL hit_addr: got %h/%h want 812a/812b", g.alo, g.ahi);
        end
        n_chk++;
        if (g.plo !== mem[16'h812A] || g.phi !== mem[16'h812B] || g.idx !== 4'd0) begin
            n_fail++;
            $display("FAIL hit_data: got %h %h idx %0d want %h %h idx 0",
                     g.plo, g.phi, g.idx, mem[16'h812A], mem[16'h812B]);
        end
        n_chk++;
        if (g !== e) begin n_fail++; $display("FAIL hit_model: got %h want %h", g, e); end
    endtask

    task automatic test_miss();
        res_t g, e;
        int lat;
        logic b0;
        m_predict(8'd21, e);
        do_check(8'd21, g, lat, b0);
        n_chk++;
        if (lat != 1 || g.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_result: got lat %0d hit %b want 1 0", lat, g.hit);
        end
        n_chk++;
        if (g.alo !== 16'h812B || g.alo !== e.alo) begin
            n_fail++;
            $display("FAIL miss_vram_a: got %h want 812b", g.alo);
        end
    endtask

    task automatic test_priority();
        res_t g, e;
        int lat;
        logic b0;
        bit   exp_hit [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0] exp_idx [3] = '{4'd2, 4'd5, 4'd0};
        m_clear();
        mq[0] = ent(8'd16, 8'd20, 8'h12, 8'h00);
        mq[2] = ent(8'd20, 8'd40, 8'h30, 8'h10);
        mq[5] = ent(8'd30, 8'd40, 8'h44, 8'h80);
        do_start(8'd25, 8'h00);
        for (int k = 0; k < 3; k++) begin
            m_predict(8'd40, e);
            do_check(8'd40, g, lat, b0);
            n_chk++;
            if (g.hit !== exp_hit[k] || lat != (exp_hit[k] ? 5 : 1) ||
                (exp_hit[k] && g.idx !== exp_idx[k])) begin
                n_fail++;
                $display("FAIL priority_%0d: got hit %b idx %0d lat %0d want %b %0d",
                         k, g.hit, g.idx, lat, exp_hit[k], exp_idx[k]);
            end
            n_chk++;
            if ((e.hit && g !== e) || (!e.hit && g.alo !== e.alo)) begin
                n_fail++;
                $display("FAIL priority_model_%0d: got %h want %h", k, g, e);
            end
        end
    endtask

    task automatic test_flips();
        res_t g, e;
        int lat;
        logic b0;
        logic [7:0] hb, hr;
        m_clear();
        mq[0] = ent(8'd16, 8'd20, 8'h12, 8'h60);
        mem[16'h8124] = 8'h01;
        hb = mem[16'h8125];
        hr = {<<{hb}};
        do_start(8'd5, 8'h00);
        m_predict(8'd20, e);
        do_check(8'd20, g, lat, b0);
        n_chk++;
        if (g.alo !== 16'h8124 || g.plo !== 8'h80 || g.phi !== hr || g.fl !== 8'h60) begin
            n_fail++;
            $display("FAIL flips: got a %h lo %h hi %h fl %h want 8124 80 %h 60",
                     g.alo, g.plo, g.phi, g.fl, hr);
        end
        n_chk++;
        if (g !== e) begin n_fail++; $display("FAIL flips_model: got %h want %h", g, e); end
    endtask

    task automatic test_tall();
        res_t g, e;
        int lat;
        logic b0;
        m_clear();
        mq[0] = ent(8'd16, 8'd20, 8'h13, 8'h00);
        do_start(8'd12, 8'h04);
        m_predict(8'd20, e);
        do_check(8'd20, g, lat, b0);
        n_chk++;
        if (g.alo !== 16'h8138 || g.ahi !== 16'h8139 || lat != 5) begin
            n_fail++;
            $display("FAIL tall_addr: got %h/%h lat %0d want 8138/8139 5",
                     g.alo, g.ahi, lat);
        end
        n_chk++;
        if (g !== e) begin n_fail++; $display("FAIL tall_model: got %h want %h", g, e); end
    endtask

    task automatic test_start_check();
        logic seen;
        m_clear();
        mq[1] = ent(8'd16, 8'd60, 8'h21, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 10; i++) bus.sprite_queue_in[i] = mq[i];
        bus.LY = 8'd9;
        bus.LCDC = 8'h00;
        bus.lx = 8'd60;
        bus.start = 1'b1;
        bus.check = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.check = 1'b0;
        for (int i = 0; i < 10; i++) mused[i] = 1'b0;
        mly = 8'd9;
        mtall = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            seen = seen | bus.busy | bus.result_valid;
            @(negedge clk);
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL start_check_drop: got activity %b want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        res_t g, e;
        int lat;
        logic b0;
        m_clear();
        mq[3] = ent(8'd40, 8'd50, 8'h05, 8'h20);
        mq[7] = ent(8'd44, 8'd50, 8'hF0, 8'h40);
        do_start(8'd33, 8'h04);
        for (int k = 0; k < 2; k++) begin
            m_predict(8'd50, e);
            do_check(8'd50, g, lat, b0);
            n_chk++;
            if (g !== e || lat != 5 || b0 !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %h lat %0d busy %b want %h 5 1",
                         k, g, lat, b0, e);
            end
        end
    endtask

    task automatic test_reset_restart();
        logic [46:0] o;
        logic seen;
        res_t g, e;
        int lat;
        logic b0;
        m_clear();
        mq[0] = ent(8'd16, 8'd20, 8'h12, 8'h00);
        do_start(8'd5, 8'h00);
        @(negedge clk);
        bus.lx = 8'd20;
        bus.check = 1'b1;
        @(negedge clk);
        bus.check = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        o = {bus.vram_a, bus.busy, bus.result_valid, bus.hit, bus.pix_lo,
             bus.pix_hi, bus.flags_out, bus.sprite_idx};
        n_chk++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL midfetch_reset: got %h want 0", o);
        end
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            seen = seen | bus.result_valid;
        end
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            seen = seen | bus.result_valid;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_result: got %b want 0", seen);
        end
        for (int i = 0; i < 10; i++) mused[i] = 1'b0;
        mva = '0;
        mq[1] = ent(8'd10, 8'd20, 8'h77, 8'h20);
        do_start(8'd14, 8'h00);
        m_predict(8'd20, e);
        do_check(8'd20, g, lat, b0);
        n_chk++;
        if (g !== e || g.idx !== 4'd0 || lat != 5) begin
            n_fail++;
            $display("FAIL restart_hit: got %h lat %0d want %h 5", g, lat, e);
        end
    endtask

    task automatic test_random();
        res_t g, e;
        int lat;
        logic b0;
        logic [7:0] lx;
        for (int q = 0; q < 4; q++) begin
            for (int i = 0; i < 10; i++) begin
                case ($urandom_range(0, 3))
                    0: mq[i] = '0;
                    1: mq[i] = {16'h1234, 32'($urandom())};
                    default: mq[i] = ent(8'($urandom()), 8'(8 + $urandom_range(0, 5)),
                                         8'($urandom()), 8'($urandom()));
                endcase
            end
            do_start(8'($urandom()), 8'($urandom()));
            for (int k = 0; k < 12; k++) begin
                lx = 8'(8 + $urandom_range(0, 5));
                m_predict(lx, e);
                do_check(lx, g, lat, b0);
                n_chk++;
                if (lat != (e.hit ? 5 : 1) || b0 !== 1'b1 ||
                    (e.hit && g !== e) ||
                    (!e.hit && {g.hit, g.alo} !== {1'b0, e.alo})) begin
                    n_fail++;
                    $display("FAIL random_%0d_%0d: got %h lat %0d want %h",
                             q, k, g, lat, e);
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.check = 1'b0;
        bus.lx = '0;
        bus.LY = '0;
        bus.LCDC = '0;
        bus.sprite_queue_in = '0;
        mly = '0;
        mtall = 1'b0;
        mva = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom());
        test_reset();
        test_single_hit();
        test_miss();
        test_priority();
        test_flips();
        test_tall();
        test_start_check();
        test_back_to_back();
        test_reset_restart();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mode_3_sprite_fetch.md
# mode_3_sprite_fetch

Pixel-transfer (mode 3) sprite fetcher, directly downstream of the OAM search stage. At `start` it latches the line's 10-entry sprite queue. For each `check` request at pixel position `lx` it finds the first unused queued sprite whose X equals `lx` and fetches that sprite's two tile-row bytes from VRAM. It returns the row bytes, with X-flip applied, plus the sprite flags to the pixel mixer.

## Interface
Parameters:
- `SPRITE_COUNT`, 10, number of queue entries.
- `VRAM_BASE`, 16'h8000, base address of sprite tile data.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse at mode 3 entry; latches queue, `LY`, `LCDC[2]`; clears used mask.
- `sprite_queue_in`  in  [9:0][47:0]  per-entry fields: {oam addr[47:32], Y[31:24], X[23:16], tile[15:8], flags[7:0]}.
- `LCDC`  in  8  only bit 2 is used (sprite height).
- `LY`  in  8  current line.
- `lx`  in  8  pixel position in OAM X coordinates (screen X + 8); sampled with `check`.
- `check`  in  1  one-cycle request pulse; ignored while `busy`.
- `vram_dout`  in  8  VRAM read data, 2-cycle read latency.
- `vram_a`  out  16  VRAM read address, registered.
- `busy`  out  1  high from accepted `check` until `result_valid`.
- `result_valid`  out  1  one-cycle pulse.
- `hit`  out  1  qualified by `result_valid`.
- `pix_lo`, `pix_hi`  out  8 each  tile row low/high bit-planes, X-flip applied.
- `flags_out`  out  8  flags of the fetched sprite.
- `sprite_idx`  out  4  queue index of the fetched sprite.

## Operation
- Entry validity: an entry is valid iff addr[15:8] == 8'hFE. Zeroed entries are empty.
- `used[9:0]` mask: cleared by `start`; bit set when that entry is fetched. Each sprite is fetched at most once per line.
- Match: entry is valid, not used, and X == `lx`. With several matches, the lowest index wins. The caller re-issues `check` at the same `lx` to retrieve the rest.
- Height h is 16 if latched LCDC[2] is 1, else 8.
- Row computation:
  - row = (LY + 16 − Y) mod 256, truncated to 4 bits (h=16) or 3 bits (h=8).
  - If flags[6] (Y-flip), row = h−1−row.
  - If h=16, tile bit 0 is forced to 0.
- Addresses, all 16-bit, wrapping:
  - lo = VRAM_BASE + tile·16 + row·2.
  - hi = lo + 1.
- If flags[5] (X-flip), `pix_lo`/`pix_hi` are bit-reversed.
- States:
  - IDLE: `check` → SCAN.
  - SCAN: on miss, pulse `result_valid` with `hit`=0 → IDLE. On hit, register `vram_a`=lo, set used bit → WAIT_LO.
  - WAIT_LO: 2 cycles, then capture `vram_dout` into lo, register `vram_a`=hi → WAIT_HI.
  - WAIT_HI: 2 cycles, then capture hi → OUT.
  - OUT: `result_valid`=1, `hit`=1 → IDLE.
- `start` in any state: re-latch, clear `used`, abort any fetch without a result, go to IDLE. `start` and `check` in the same cycle: `start` wins and `check` is dropped.
- Reset values: `vram_a`=0, `busy`=0, `result_valid`=0, `hit`=0, `pix_lo`=`pix_hi`=0, `flags_out`=0, `sprite_idx`=0, `used`=0, latched queue=0, state IDLE. Reset mid-fetch clears everything immediately (asynchronous).

## Timing
- `check` sampled at edge k. `busy` is high after edge k.
- Miss: `result_valid` high for the cycle after edge k+1; `busy` falls at edge k+2.
- Hit:
  - `vram_a`=lo after edge k+1.
  - `vram_dout` for lo sampled at edge k+3; `vram_a`=hi after edge k+3.
  - hi sampled at edge k+5.
  - `result_valid`/`hit` high after edge k+5 for one cycle; outputs hold until the next result.
- Hit latency is 5 cycles, miss latency 1 cycle. Back-to-back `check` is accepted the cycle `busy` is low.
- `vram_a` holds its last value between fetches.

## Configuration
- `SPRITE_TALL_EN` defined: LCDC[2] selects 8x16 sprites as above.
- Not defined: LCDC[2] ignored; h is always 8 and tile bit 0 is never forced.

## Test plan
- Single hit:
  - Stimulus: entry0 {FE00, Y=16, X=20, tile=12, flags=00}, LY=5, `check` `lx`=20.
  - Response: `vram_a` 812A then 812B, `result_valid`+`hit` 5 cycles after `check`, `pix_lo`/`pix_hi` equal the supplied bytes, `sprite_idx`=0.
- Miss:
  - Stimulus: same queue, `lx`=21.
  - Response: `result_valid`=1, `hit`=0 one cycle after; `vram_a` unchanged.
- Priority and used mask:
  - Stimulus: entries 2 and 5 with X=40; three `check`s at `lx`=40.
  - Response: hit `sprite_idx`=2, then hit 5, then miss.
- Flips:
  - Stimulus: flags=60, Y=16, LY=5, tile=12; lo VRAM byte 01.
  - Response: row 2, `vram_a`=8124, `pix_lo`=80.
- Tall sprite (`SPRITE_TALL_EN`):
  - Stimulus: LCDC[2]=1, tile=13, Y=16, LY=12.
  - Response: `vram_a`=8138/8139. Without the macro: row 4, `vram_a`=8138 from tile 13 → 8130+8=8138 (tile kept 13: 8138).
- Reset and restart:
  - Stimulus: `rst` asserted during WAIT_HI.
  - Response: all outputs 0 immediately, no `result_valid`. `start` with a new queue plus a `check` hits normally with `used` cleared.
